// File: rtl/triangle_smoother_mc.sv
// Multi-channel triangle/boxcar/bypass smoother for time-multiplexed ADC samples.
// Stage 1 updates the channel history; stage 2 filters the captured channel and registers the result.
module triangle_smoother_mc_lane #(
  parameter int ADC_BITS = 12,
  parameter int N        = 3,
  parameter int FW       = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             clr,
  input  logic [ADC_BITS-1:0]              sample,
  output logic [N-1:0][ADC_BITS-1:0]       hist,
  output logic [FW-1:0]                    fill
);
  // hist[0] is the newest tap; a same-edge clear keeps only the incoming sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (push) begin
      if (clr) begin
        hist <= {{((N-1)*ADC_BITS){1'b0}}, sample};
        fill <= FW'(1);
      end else begin
        hist <= {hist[N-2:0], sample};
        fill <= (fill == FW'(N)) ? fill : fill + 1'b1;
      end
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end
  end
endmodule

module triangle_smoother_mc #(
  parameter int ADC_BITS  = 12,
  parameter int HALF_LOG2 = 1,
  parameter int NUM_CH    = 4,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADC_BITS-1:0] ADC_reading,
  input  logic [CH_W-1:0]     ADC_ch,
  input  logic                ADC_en,
  input  logic [1:0]          mode,
  input  logic                clr_en,
  input  logic [CH_W-1:0]     clr_ch,
  output logic [ADC_BITS-1:0] smooth_out,
  output logic [CH_W-1:0]     out_ch,
  output logic                new_out,
  output logic                primed,
  output logic                drop_err
);
  localparam int K1    = 1 << HALF_LOG2;
  localparam int N     = 2 * K1 - 1;
  localparam int FW    = $clog2(N + 1);
  localparam int ACC_W = ADC_BITS + 2 * HALF_LOG2 + 1;
  localparam int BOX_W = ADC_BITS + HALF_LOG2 + 1;

  logic [NUM_CH-1:0][N-1:0][ADC_BITS-1:0] hist;
  logic [NUM_CH-1:0][FW-1:0]              fill;
  logic                                   adc_ok;

  assign adc_ok = {1'b0, ADC_ch} < (CH_W+1)'(NUM_CH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    triangle_smoother_mc_lane #(.ADC_BITS(ADC_BITS), .N(N), .FW(FW)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .push   (ADC_en && (ADC_ch == CH_W'(c))),
      .clr    (clr_en && (clr_ch == CH_W'(c))),
      .sample (ADC_reading),
      .hist   (hist[c]),
      .fill   (fill[c])
    );
  end

  logic            s1_vld, s1_drop;
  logic [CH_W-1:0] s1_ch;
  logic [1:0]      s1_mode;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld  <= 1'b0;
      s1_drop <= 1'b0;
      s1_ch   <= '0;
      s1_mode <= '0;
    end else begin
      s1_vld  <= ADC_en && adc_ok;
      s1_drop <= ADC_en && !adc_ok;
      s1_ch   <= ADC_ch;
      s1_mode <= mode;
    end
  end

  // Between E0 and E1 the lanes already hold the post-update history and fill
  logic [N-1:0][ADC_BITS-1:0] hsel;
  logic [FW-1:0]              fsel;
  logic [ACC_W-1:0]           tri_acc;
  logic [BOX_W-1:0]           box_acc;
  logic [ADC_BITS-1:0]        res;
  logic                       prm;
  logic                       unused_bits;

  assign hsel = hist[s1_ch];
  assign fsel = fill[s1_ch];

  function automatic int tri_w(input int i);
    int k;
    k = K1 - 1;
    return K1 - ((i > k) ? i - k : k - i);
  endfunction

  always_comb begin
    tri_acc = ACC_W'(K1 * K1 / 2);
    box_acc = BOX_W'(K1 / 2);
    for (int i = 0; i < N; i++)
      tri_acc = tri_acc + ACC_W'(hsel[i]) * ACC_W'(tri_w(i));
    for (int i = 0; i < K1; i++)
      box_acc = box_acc + BOX_W'(hsel[i]);
    case (s1_mode)
      2'b00: begin
        res = hsel[0];
        prm = fsel >= FW'(1);
      end
      2'b10: begin
        res = box_acc[HALF_LOG2 +: ADC_BITS];
        prm = fsel >= FW'(K1);
      end
      default: begin
        res = tri_acc[2*HALF_LOG2 +: ADC_BITS];
        prm = fsel >= FW'(N);
      end
    endcase
  end

  // Rounded sums fit below the top accumulator bit, so truncation is exact
  assign unused_bits = ^{tri_acc[ACC_W-1], tri_acc[2*HALF_LOG2-1:0],
                         box_acc[BOX_W-1], box_acc[HALF_LOG2-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smooth_out <= '0;
      out_ch     <= '0;
      new_out    <= 1'b0;
      primed     <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      new_out  <= s1_vld;
      drop_err <= s1_drop;
      if (s1_vld) begin
        smooth_out <= res;
        out_ch     <= s1_ch;
        primed     <= prm;
      end
    end
  end
endmodule

// File: tb/tb_triangle_smoother_mc.sv
// Bench for triangle_smoother_mc: three configurations share one stimulus stream and a queue-based model.
module tb_triangle_smoother_mc;
  localparam int ND = 3;

  logic        clk, reset, ADC_en, clr_en;
  logic [11:0] ADC_reading;
  logic [1:0]  ADC_ch, mode, clr_ch;
  logic [11:0] so [ND];
  logic [1:0]  oc [ND];
  logic        nw [ND];
  logic        pr [ND];
  logic        de [ND];

  int tests = 0, fails = 0;

  triangle_smoother_mc #(.ADC_BITS(12), .HALF_LOG2(1), .NUM_CH(4)) dut0 (
    .clk(clk), .reset(reset), .ADC_reading(ADC_reading), .ADC_ch(ADC_ch), .ADC_en(ADC_en),
    .mode(mode), .clr_en(clr_en), .clr_ch(clr_ch), .smooth_out(so[0]), .out_ch(oc[0]),
    .new_out(nw[0]), .primed(pr[0]), .drop_err(de[0]));
  triangle_smoother_mc #(.ADC_BITS(12), .HALF_LOG2(1), .NUM_CH(3)) dut1 (
    .clk(clk), .reset(reset), .ADC_reading(ADC_reading), .ADC_ch(ADC_ch), .ADC_en(ADC_en),
    .mode(mode), .clr_en(clr_en), .clr_ch(clr_ch), .smooth_out(so[1]), .out_ch(oc[1]),
    .new_out(nw[1]), .primed(pr[1]), .drop_err(de[1]));
  triangle_smoother_mc #(.ADC_BITS(12), .HALF_LOG2(2), .NUM_CH(4)) dut2 (
    .clk(clk), .reset(reset), .ADC_reading(ADC_reading), .ADC_ch(ADC_ch), .ADC_en(ADC_en),
    .mode(mode), .clr_en(clr_en), .clr_ch(clr_ch), .smooth_out(so[2]), .out_ch(oc[2]),
    .new_out(nw[2]), .primed(pr[2]), .drop_err(de[2]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int hl(input int d);
    return (d == 2) ? 2 : 1;
  endfunction
  function automatic int nch(input int d);
    return (d == 1) ? 3 : 4;
  endfunction

  // Model: per-channel queue of samples, newest first; its size is the fill level
  int mh [ND][4][$];
  bit s1v [ND], s1d [ND], s1p [ND];
  int s1val [ND], s1ch [ND];
  bit xn [ND], xd [ND], xp [ND];
  int xv [ND], xc [ND];

  function automatic void calc(input int d, input int c, input int md, output int v, output bit p);
    int k1, n, sz, s, tap;
    k1 = 1 << hl(d);
    n  = 2 * k1 - 1;
    sz = mh[d][c].size();
    s  = 0;
    if (md == 0) begin
      v = mh[d][c][0];
      p = sz >= 1;
    end else if (md == 2) begin
      for (int i = 0; i < k1; i++) s += (i < sz) ? mh[d][c][i] : 0;
      v = (s + k1 / 2) / k1;
      p = sz >= k1;
    end else begin
      for (int i = 0; i < n; i++) begin
        tap = (i < sz) ? mh[d][c][i] : 0;
        s += (k1 - ((i > k1 - 1) ? i - (k1 - 1) : (k1 - 1) - i)) * tap;
      end
      v = (s + k1 * k1 / 2) / (k1 * k1);
      p = sz >= n;
    end
  endfunction

  task automatic model_reset;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < 4; c++) mh[d][c].delete();
      s1v[d] = 0; s1d[d] = 0; s1p[d] = 0; s1val[d] = 0; s1ch[d] = 0;
      xn[d] = 0; xd[d] = 0; xp[d] = 0; xv[d] = 0; xc[d] = 0;
    end
  endtask

  task automatic model_edge;
    int v;
    bit p;
    for (int d = 0; d < ND; d++) begin
      xn[d] = s1v[d];
      xd[d] = s1d[d];
      if (s1v[d]) begin
        xv[d] = s1val[d]; xc[d] = s1ch[d]; xp[d] = s1p[d];
      end
      s1v[d] = 0;
      s1d[d] = 0;
      if (clr_en && int'(clr_ch) < nch(d)) mh[d][clr_ch].delete();
      if (ADC_en) begin
        if (int'(ADC_ch) >= nch(d)) s1d[d] = 1;
        else begin
          mh[d][ADC_ch].push_front(int'(ADC_reading));
          if (mh[d][ADC_ch].size() > 2 * (1 << hl(d)) - 1) void'(mh[d][ADC_ch].pop_back());
          calc(d, int'(ADC_ch), int'(mode), v, p);
          s1v[d] = 1; s1val[d] = v; s1ch[d] = int'(ADC_ch); s1p[d] = p;
        end
      end
    end
  endtask

  task automatic drv(input bit en, input int ch, input int val, input int md, input bit ce, input int cc);
    ADC_en = en; ADC_ch = 2'(ch); ADC_reading = 12'(val); mode = 2'(md);
    clr_en = ce; clr_ch = 2'(cc);
  endtask

  task automatic cycle;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset;
    reset = 0;
    drv(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      tests++;
      if ({so[d], oc[d], nw[d], pr[d], de[d]} !== 17'd0) begin
        fails++;
        $display("FAIL reset dut%0d: got so=%0d ch=%0d new=%0b pr=%0b drop=%0b, want all 0",
                 d, so[d], oc[d], nw[d], pr[d], de[d]);
      end
    end
    reset = 1;
  endtask

  task automatic test_triangle;
    int ev [3] = '{25, 100, 200};
    bit ep [3] = '{0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drv(1, 0, 100 * (i + 1), 1, 0, 0);
      else drv(0, 0, 0, 1, 0, 0);
      cycle();
      if (i >= 1 && i <= 3) begin
        tests++;
        if (nw[0] !== 1'b1 || so[0] !== 12'(ev[i-1]) || pr[0] !== ep[i-1] || oc[0] !== 2'd0) begin
          fails++;
          $display("FAIL triangle[%0d]: got new=%0b so=%0d pr=%0b ch=%0d, want 1 %0d %0b 0",
                   i - 1, nw[0], so[0], pr[0], oc[0], ev[i-1], ep[i-1]);
        end
      end else if (i == 4) begin
        tests++;
        if (nw[0] !== 1'b0) begin
          fails++;
          $display("FAIL triangle_idle: got new=%0b, want 0", nw[0]);
        end
      end
    end
  endtask

  task automatic test_interleave;
    int ev0 [3] = '{1024, 3071, 4095};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drv(1, i % 2, (i % 2 == 0) ? 4095 : 0, 1, i < 2, i % 2);
      else drv(0, 0, 0, 1, 0, 0);
      cycle();
      if (i >= 1 && i <= 6) begin
        tests++;
        if (nw[0] !== 1'b1 || oc[0] !== 2'((i - 1) % 2) ||
            so[0] !== (((i - 1) % 2 == 0) ? 12'(ev0[(i-1)/2]) : 12'd0)) begin
          fails++;
          $display("FAIL interleave[%0d]: got new=%0b ch=%0d so=%0d, want 1 %0d %0d", i - 1,
                   nw[0], oc[0], so[0], (i - 1) % 2, ((i - 1) % 2 == 0) ? ev0[(i-1)/2] : 0);
        end
      end
    end
  endtask

  task automatic test_boxcar;
    int ev [3] = '{51, 102, 777};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drv(1, 2, 101, 2, 0, 0);
        1: drv(1, 2, 102, 2, 0, 0);
        2: drv(1, 2, 777, 0, 0, 0);
        default: drv(0, 0, 0, 0, 0, 0);
      endcase
      cycle();
      if (i >= 1) begin
        tests++;
        if (nw[0] !== 1'b1 || so[0] !== 12'(ev[i-1]) || pr[0] !== (i != 1) || oc[0] !== 2'd2) begin
          fails++;
          $display("FAIL boxcar[%0d]: got new=%0b so=%0d pr=%0b ch=%0d, want 1 %0d %0b 2",
                   i - 1, nw[0], so[0], pr[0], oc[0], ev[i-1], i != 1);
        end
      end
    end
  endtask

  task automatic test_drop;
    drv(1, 3, 123, 1, 0, 0);
    cycle();
    drv(0, 0, 0, 1, 0, 0);
    tests++;
    if (de[1] !== 1'b0) begin
      fails++;
      $display("FAIL drop_early: got drop=%0b, want 0", de[1]);
    end
    cycle();
    tests++;
    if (de[1] !== 1'b1 || nw[1] !== 1'b0) begin
      fails++;
      $display("FAIL drop: got drop=%0b new=%0b, want 1 0", de[1], nw[1]);
    end
    drv(1, 0, 50, 1, 1, 0);
    cycle();
    drv(0, 0, 0, 1, 0, 0);
    cycle();
    tests++;
    if (nw[1] !== 1'b1 || so[1] !== 12'd13 || pr[1] !== 1'b0 || de[1] !== 1'b0) begin
      fails++;
      $display("FAIL clear_push: got new=%0b so=%0d pr=%0b drop=%0b, want 1 13 0 0",
               nw[1], so[1], pr[1], de[1]);
    end
  endtask

  task automatic test_window7;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) drv(1, 1, 4095, 1, i == 0, 1);
      else drv(0, 0, 0, 1, 0, 0);
      cycle();
      if (i >= 1) begin
        tests++;
        if (nw[2] !== 1'b1 || pr[2] !== (i == 7) || (i == 7 && so[2] !== 12'd4095)) begin
          fails++;
          $display("FAIL window7[%0d]: got new=%0b pr=%0b so=%0d, want 1 %0b (4095 when primed)",
                   i - 1, nw[2], pr[2], so[2], i == 7);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    drv(1, 0, 400, 1, 0, 0);
    cycle();
    drv(0, 0, 0, 1, 0, 0);
    #2 reset = 0;
    model_reset();
    #1;
    tests++;
    if ({so[0], oc[0], nw[0], pr[0], de[0]} !== 17'd0) begin
      fails++;
      $display("FAIL reset_mid: got so=%0d ch=%0d new=%0b pr=%0b, want all 0", so[0], oc[0], nw[0], pr[0]);
    end
    #1 reset = 1;
    cycle();
    tests++;
    if (nw[0] !== 1'b0 || so[0] !== 12'd0) begin
      fails++;
      $display("FAIL reset_flush: got new=%0b so=%0d, want 0 0", nw[0], so[0]);
    end
    drv(1, 0, 400, 1, 0, 0);
    cycle();
    drv(0, 0, 0, 1, 0, 0);
    cycle();
    tests++;
    if (nw[0] !== 1'b1 || so[0] !== 12'd100 || pr[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_refill: got new=%0b so=%0d pr=%0b, want 1 100 0", nw[0], so[0], pr[0]);
    end
  endtask

  task automatic test_random;
    int v;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: v = 4095;
        1: v = $urandom_range(0, 3);
        default: v = $urandom_range(0, 4095);
      endcase
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 3), v, $urandom_range(0, 3),
          $urandom_range(0, 9) == 0, $urandom_range(0, 3));
      cycle();
      for (int d = 0; d < ND; d++) begin
        tests++;
        if (nw[d] !== xn[d] || de[d] !== xd[d] || so[d] !== 12'(xv[d]) ||
            oc[d] !== 2'(xc[d]) || pr[d] !== xp[d]) begin
          fails++;
          $display("FAIL random[%0d] dut%0d: got new=%0b drop=%0b so=%0d ch=%0d pr=%0b, want %0b %0b %0d %0d %0b",
                   n, d, nw[d], de[d], so[d], oc[d], pr[d], xn[d], xd[d], xv[d], xc[d], xp[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_interleave();
    test_boxcar();
    test_drop();
    test_window7();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
